// File: rtl/msx_pkg.sv
// msx_pkg: shared MSX constants for PPI port offsets, port C bit roles and 8255 mode.
package msx_pkg;

    localparam logic [1:0] PPI_PA   = 2'd0;
    localparam logic [1:0] PPI_PB   = 2'd1;
    localparam logic [1:0] PPI_PC   = 2'd2;
    localparam logic [1:0] PPI_CTRL = 2'd3;

    localparam int PC_CASMOT = 4;
    localparam int PC_CASWR  = 5;
    localparam int PC_CAPS   = 6;
    localparam int PC_CLICK  = 7;

    localparam logic [7:0] MODE_RESET = 8'h9B;

endpackage

// File: rtl/msx_ppi_if.sv
// msx_ppi_if: T80 I/O bus view of the PPI; mode exposes the last 8255 mode word written.
interface msx_ppi_if;
    logic [7:0] a;
    logic [7:0] d_i;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic       m1_n;
    logic [7:0] d_o;
    logic       d_oe;
    logic [7:0] mode;

    modport master (
        output a, d_i, iorq_n, rd_n, wr_n, m1_n,
        input  d_o, d_oe, mode
    );

    modport slave (
        input  a, d_i, iorq_n, rd_n, wr_n, m1_n,
        output d_o, d_oe, mode
    );
endinterface

// File: rtl/msx_sync2.sv
// msx_sync2: parameterised-width two-flop synchroniser for asynchronous inputs.
module msx_sync2 #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/msx_ppi.sv
// msx_ppi: 8255-compatible PPI fixed in MSX mode 82h; port A = slot select, B = keyboard
// columns, C = keyboard row plus cassette/CAPS/click controls.
module msx_ppi
    import msx_pkg::*;
#(
    parameter logic [7:0] PORT_BASE   = 8'hA8,
    parameter logic [7:0] PORT_A_INIT = 8'h00,
    parameter logic [7:0] PORT_C_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    msx_ppi_if.slave   bus,
    input  logic [7:0] kb_col,
    output logic [7:0] slot_sel,
    output logic [3:0] kb_row,
    output logic       cas_motor_n,
    output logic       cas_wr,
    output logic       caps_led_n,
    output logic       click
);

    logic [7:0] r_pa;
    logic [7:0] r_pc;
    logic [7:0] r_mode;
    logic [7:0] r_d_o;
    logic       r_d_oe;
    logic       r_wr_q;
    logic       r_wr_q_prev;

    logic [7:0] w_kb_col_s;
    logic [7:0] w_pa_nxt;
    logic [7:0] w_pc_nxt;
    logic [7:0] w_mode_nxt;
    logic [7:0] w_rd_data;
    logic [7:0] w_bit;
    logic       w_sel;
    logic       w_rd;
    logic       w_wr_fall;
    logic       w_mode_set;
    logic       w_bsr;

    msx_sync2 #(.W(8), .RST_VAL(8'hFF)) u_kb_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (kb_col),
        .o_q   (w_kb_col_s)
    );

    // One write per I/O cycle: only the registered high-to-low transition of wr_n counts.
    always_comb begin
        w_sel      = ~bus.iorq_n & bus.m1_n & (bus.a[7:2] == PORT_BASE[7:2]);
        w_rd       = w_sel & ~bus.rd_n;
        w_wr_fall  = r_wr_q_prev & ~r_wr_q & w_sel;
        w_mode_set = w_wr_fall & (bus.a[1:0] == PPI_CTRL) & bus.d_i[7];
        w_bsr      = w_wr_fall & (bus.a[1:0] == PPI_CTRL) & ~bus.d_i[7];
        w_bit      = 8'h01 << bus.d_i[3:1];
        w_pa_nxt   = w_mode_set ? 8'h00 :
                     (w_wr_fall && bus.a[1:0] == PPI_PA) ? bus.d_i : r_pa;
        w_pc_nxt   = w_mode_set ? 8'h00 :
                     (w_wr_fall && bus.a[1:0] == PPI_PC) ? bus.d_i :
                     w_bsr ? (bus.d_i[0] ? (r_pc | w_bit) : (r_pc & ~w_bit)) : r_pc;
        w_mode_nxt = w_mode_set ? bus.d_i : r_mode;
        w_rd_data  = (bus.a[1:0] == PPI_PA) ? r_pa :
                     (bus.a[1:0] == PPI_PB) ? w_kb_col_s :
                     (bus.a[1:0] == PPI_PC) ? r_pc : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pa        <= PORT_A_INIT;
            r_pc        <= PORT_C_INIT;
            r_mode      <= MODE_RESET;
            r_d_o       <= 8'hFF;
            r_d_oe      <= 1'b0;
            r_wr_q      <= 1'b1;
            r_wr_q_prev <= 1'b1;
        end else begin
            r_pa        <= w_pa_nxt;
            r_pc        <= w_pc_nxt;
            r_mode      <= w_mode_nxt;
            r_d_o       <= w_rd ? w_rd_data : 8'hFF;
            r_d_oe      <= w_rd;
            r_wr_q      <= bus.wr_n;
            r_wr_q_prev <= r_wr_q;
        end
    end

    assign bus.d_o     = r_d_o;
    assign bus.d_oe    = r_d_oe;
    assign bus.mode    = r_mode;
    assign slot_sel    = r_pa;
    assign kb_row      = r_pc[3:0];
    assign cas_motor_n = r_pc[PC_CASMOT];
    assign cas_wr      = r_pc[PC_CASWR];
    assign caps_led_n  = r_pc[PC_CAPS];
    assign click       = r_pc[PC_CLICK];

endmodule

// File: tb/tb_msx_ppi.sv
// tb_msx_ppi: random and directed bus traffic against a cycle-level behavioural PPI model.
module tb_msx_ppi;

    logic       clk;
    logic       reset;
    logic [7:0] kb_col;
    logic [7:0] slot_sel;
    logic [3:0] kb_row;
    logic       cas_motor_n, cas_wr, caps_led_n, click;
    logic [7:0] rd_d;
    logic       rd_oe;

    int n_chk = 0;
    int n_pass = 0;
    int n_slot_chg = 0;
    logic [7:0] prev_slot = 8'h00;

    msx_ppi_if bus ();

    msx_ppi dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .kb_col      (kb_col),
        .slot_sel    (slot_sel),
        .kb_row      (kb_row),
        .cas_motor_n (cas_motor_n),
        .cas_wr      (cas_wr),
        .caps_led_n  (caps_led_n),
        .click       (click)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    endtask

    // Reference: wr_n history in bus samples, kb_col seen two samples late, read data one sample late.
    logic [7:0] m_pa, m_pc, m_do;
    logic       m_oe;
    logic [7:0] kb_h [2];
    logic       wr_h [2];
    bit         m_valid = 0;

    always @(posedge clk) begin : model
        logic       sel;
        logic [7:0] rv;
        sel = !bus.iorq_n && bus.m1_n && (bus.a >> 2) == (8'hA8 >> 2);
        if (reset) begin
            m_pa = 8'h00; m_pc = 8'h00; m_do = 8'hFF; m_oe = 1'b0;
            kb_h[0] = 8'hFF; kb_h[1] = 8'hFF; wr_h[0] = 1'b1; wr_h[1] = 1'b1;
            m_valid = 1;
        end else begin
            case (bus.a[1:0])
                2'd0: rv = m_pa;
                2'd1: rv = kb_h[1];
                2'd2: rv = m_pc;
                default: rv = 8'hFF;
            endcase
            m_oe = sel && !bus.rd_n;
            m_do = m_oe ? rv : 8'hFF;
            if (wr_h[1] && !wr_h[0] && sel) begin
                case (bus.a[1:0])
                    2'd0: m_pa = bus.d_i;
                    2'd2: m_pc = bus.d_i;
                    2'd3: if (bus.d_i[7]) begin m_pa = 8'h00; m_pc = 8'h00; end
                          else m_pc[bus.d_i[3:1]] = bus.d_i[0];
                    default: ;
                endcase
            end
            kb_h[1] = kb_h[0]; kb_h[0] = kb_col;
            wr_h[1] = wr_h[0]; wr_h[0] = bus.wr_n;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("d_o", bus.d_o, m_do);
            check("d_oe", 8'(bus.d_oe), 8'(m_oe));
            check("slot_sel", slot_sel, m_pa);
            check("port_c", {click, caps_led_n, cas_wr, cas_motor_n, kb_row}, m_pc);
        end
        if (slot_sel !== prev_slot) n_slot_chg++;
        prev_slot = slot_sel;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [7:0] addr, input logic [7:0] data, input int hold);
        bus.a = addr; bus.d_i = data; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        repeat (hold) tick();
        bus.wr_n = 1'b1; bus.iorq_n = 1'b1;
        tick();
    endtask

    task automatic io_read(input logic [7:0] addr, output logic [7:0] data, output logic oe);
        bus.a = addr; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
        tick();
        tick();
        data = bus.d_o; oe = bus.d_oe;
        bus.rd_n = 1'b1; bus.iorq_n = 1'b1;
        tick();
    endtask

    function automatic logic [7:0] port_c();
        return {click, caps_led_n, cas_wr, cas_motor_n, kb_row};
    endfunction

    initial begin
        reset = 1'b1; kb_col = 8'hFF;
        bus.a = 8'h00; bus.d_i = 8'h00;
        bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.m1_n = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_slot", slot_sel, 8'h00);
        check("rst_row", 8'(kb_row), 8'h00);
        check("rst_do", bus.d_o, 8'hFF);
        check("rst_mode", bus.mode, 8'h9B);
        io_read(8'hA8, rd_d, rd_oe);
        check("rd_a8", rd_d, 8'h00);
        check("rd_a8_oe", 8'(rd_oe), 8'h01);
        io_read(8'hAB, rd_d, rd_oe);
        check("rd_ab", rd_d, 8'hFF);

        n_slot_chg = 0;
        bus.a = 8'hA8; bus.d_i = 8'h5A; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        tick();
        check("wr_lat1", slot_sel, 8'h00);
        tick();
        check("wr_lat2", slot_sel, 8'h5A);
        repeat (4) tick();
        bus.wr_n = 1'b1; bus.iorq_n = 1'b1;
        tick();
        check("wr_once", 8'(n_slot_chg), 8'h01);

        io_write(8'hAA, 8'hF3, 2);
        check("pc_f3", port_c(), 8'hF3);
        io_write(8'hAB, 8'h0E, 3);
        check("pc_bsr_clr", port_c(), 8'h73);
        io_write(8'hAB, 8'h01, 2);
        check("pc_bsr_set", port_c(), 8'h73);
        check("click", 8'(click), 8'h00);
        check("kb_row", 8'(kb_row), 8'h03);

        io_write(8'hA8, 8'hFF, 2);
        io_write(8'hAA, 8'hFF, 2);
        io_write(8'hAB, 8'h82, 2);
        check("mode_pa", slot_sel, 8'h00);
        check("mode_pc", port_c(), 8'h00);
        check("mode_reg", bus.mode, 8'h82);

        kb_col = 8'hFE; bus.a = 8'hA9; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
        tick(); tick();
        check("kb_lat2", bus.d_o, 8'hFF);
        tick();
        check("kb_lat3", bus.d_o, 8'hFE);
        bus.m1_n = 1'b0;
        tick(); tick();
        check("m1_oe", 8'(bus.d_oe), 8'h00);
        check("m1_do", bus.d_o, 8'hFF);
        bus.m1_n = 1'b1; bus.rd_n = 1'b1; bus.iorq_n = 1'b1;
        tick();

        io_write(8'hAA, 8'hF3, 2);
        bus.a = 8'hAA; bus.d_i = 8'h55; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid", port_c(), 8'h00);
        reset = 1'b0;
        tick();
        check("rst_hold", port_c(), 8'h00);
        tick();
        check("rst_rewr", port_c(), 8'h55);
        bus.wr_n = 1'b1; bus.iorq_n = 1'b1;
        tick();

        for (int i = 0; i < 400; i++) begin
            int op;
            logic [7:0] ad;
            op = $urandom_range(0, 19);
            ad = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(8'hA8 + $urandom_range(0, 3));
            bus.m1_n = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) kb_col = 8'($urandom);
            if (op < 10) io_write(ad, 8'($urandom), $urandom_range(2, 5));
            else if (op < 19) io_read(ad, rd_d, rd_oe);
            else begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            if ($urandom_range(0, 1) == 0) tick();
        end
        bus.m1_n = 1'b1;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
